bus_loader: RTL and testbench
=============================

// Module: bus_loader
// PURPOSE
//   Destination end of the 16-bit common bus. Holds AR, PC, DR, AC, IR and TR.
//   Decodes a 3-bit load_code (same encoding as bus_code) to capture bus_data
//   into one register, or to write bus_data to memory at M[AR].
//   Supplies the *_outdata values that the bus source mux selects from.
//   Memory writes use a req/ack handshake with a timeout.
// PARAMETERS
//   AW       12   address width (AR, PC)
//   DW       16   data width (DR, AC, IR, TR, bus)
//   WR_TMO   15   cycles to wait for mem_wr_ack before abort (1..255)
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high
//   bus_data     in   DW  common bus value
//   alu_data     in   DW  ALU result (AC load source)
//   load_code    in   3   001 AR, 010 PC, 011 DR, 100 AC(alu_data), 101 IR, 110 TR, 111 MEM write, 000 none
//   inc_mask     in   5   increment {TR,AC,DR,PC,AR} (bit0 = AR)
//   clr_mask     in   5   clear, same bit order
//   ar_outdata   out  AW  AR;  pc_outdata out AW PC
//   dr_outdata   out  DW  DR;  ac_outdata out DW AC
//   ir_outdata   out  DW  IR;  tr_outdata out DW TR
//   mem_addr     out  AW  write address (AR captured at request)
//   mem_wdata    out  DW  write data (bus_data captured at request)
//   mem_wr_req   out  1   write request, level
//   mem_wr_ack   in   1   memory accepted write
//   busy         out  1   write in progress; sequencer must stall
//   wr_err       out  1   sticky: write timed out; cleared by reset only
// BEHAVIOUR
//   Reset: all registers, mem_addr, mem_wdata, mem_wr_req, busy, wr_err = 0; FSM = IDLE.
//   Register update, per register, when busy=0, on the clk edge:
//     clr > load > inc. Clear -> 0. Load -> bus_data (AR/PC take bus_data[AW-1:0]).
//     Increment -> +1 modulo 2^width (AR/PC FFF->000, DR/AC/TR FFFF->0000).
//     IR has no inc/clr; only load_code 101 writes it. AC load takes alu_data.
//   Latency: value visible on *_outdata the cycle after the command edge.
//   Load and increment of different registers in the same cycle both take effect.
//   FSM IDLE -> WRITE on load_code=111 with busy=0:
//     mem_addr<=AR, mem_wdata<=bus_data, mem_wr_req<=1, busy<=1, timer<=0.
//     inc/clr masks in that cycle still apply (AR may increment; the address is pre-increment).
//   WRITE: mem_wr_req and busy held high; addr/data held stable.
//     mem_wr_ack=1 -> IDLE next edge: req=0, busy=0.
//     else timer+1; timer reaches WR_TMO-1 without ack -> IDLE, req=0, busy=0, wr_err<=1.
//     Ack and timeout on the same edge -> ack wins; wr_err unchanged.
//   While busy=1: load_code, inc_mask and clr_mask are ignored (no register changes).
//   mem_wr_ack while IDLE is ignored.
//   Reset mid-write: req drops on the reset edge; no write is counted, wr_err=0.
// TESTING
//   1 Load: bus_data=0xABCD, code 011 -> dr_outdata=ABCD next cycle; code 001 -> ar_outdata=BCD.
//   2 Wrap: PC=FFF, inc bit1 -> 000. TR=FFFF, inc bit4 -> 0000. clr+inc AC=5 -> 0.
//   3 Write: AR=0x123, bus=0x5A5A, code 111 with AR inc -> req=1, addr=123, data=5A5A,
//     AR=124. Ack on the 3rd cycle -> busy=0 the next cycle. DR load issued during busy -> DR unchanged.
//   4 Timeout: WR_TMO=4, no ack -> req falls after 4 cycles and wr_err=1. The next write works
//     and wr_err stays 1.
//   5 Reset during WRITE -> req=0, busy=0, all regs 0 on the next cycle.
//   6 AC load: code 100, alu_data=0x0F0F, bus_data=0xFFFF -> ac_outdata=0F0F.

Source files
------------

// File: rtl/bus_loader.sv
// Destination end of the common bus: holds AR, PC, DR, AC, IR, TR and issues
// memory writes of bus_data to M[AR] through a req/ack handshake with timeout.
module bus_loader #(
    parameter int unsigned AW     = 12,
    parameter int unsigned DW     = 16,
    parameter int unsigned WR_TMO = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [DW-1:0] i_bus_data,
    input  logic [DW-1:0] i_alu_data,
    input  logic [2:0]    i_load_code,
    input  logic [4:0]    i_inc_mask,
    input  logic [4:0]    i_clr_mask,
    output logic [AW-1:0] o_ar_outdata,
    output logic [AW-1:0] o_pc_outdata,
    output logic [DW-1:0] o_dr_outdata,
    output logic [DW-1:0] o_ac_outdata,
    output logic [DW-1:0] o_ir_outdata,
    output logic [DW-1:0] o_tr_outdata,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_wr_req,
    input  logic          i_mem_wr_ack,
    output logic          o_busy,
    output logic          o_wr_err
);

    localparam logic [2:0] CodeAr  = 3'b001;
    localparam logic [2:0] CodePc  = 3'b010;
    localparam logic [2:0] CodeDr  = 3'b011;
    localparam logic [2:0] CodeAc  = 3'b100;
    localparam logic [2:0] CodeIr  = 3'b101;
    localparam logic [2:0] CodeTr  = 3'b110;
    localparam logic [2:0] CodeMem = 3'b111;

    localparam logic [7:0] TmoLast = 8'(WR_TMO - 1);

    typedef enum logic {StIdle, StWrite} state_e;

    state_e        r_state;
    state_e        w_state_next;

    logic [AW-1:0] r_ar, r_pc, r_mem_addr;
    logic [DW-1:0] r_dr, r_ac, r_ir, r_tr, r_mem_wdata;
    logic [7:0]    r_timer;
    logic          r_wr_err;

    logic [AW-1:0] w_ar_d, w_pc_d;
    logic [DW-1:0] w_dr_d, w_ac_d, w_ir_d, w_tr_d;
    logic          w_busy;
    logic          w_start;

    assign w_busy  = (r_state == StWrite);
    assign w_start = !w_busy && (i_load_code == CodeMem);

    // Per-register priority: clear, then load, then increment; frozen while busy.
    always_comb begin
        w_ar_d = r_ar;
        w_pc_d = r_pc;
        w_dr_d = r_dr;
        w_ac_d = r_ac;
        w_ir_d = r_ir;
        w_tr_d = r_tr;
        if (!w_busy) begin
            if (i_clr_mask[0])              w_ar_d = '0;
            else if (i_load_code == CodeAr) w_ar_d = i_bus_data[AW-1:0];
            else if (i_inc_mask[0])         w_ar_d = r_ar + AW'(1);

            if (i_clr_mask[1])              w_pc_d = '0;
            else if (i_load_code == CodePc) w_pc_d = i_bus_data[AW-1:0];
            else if (i_inc_mask[1])         w_pc_d = r_pc + AW'(1);

            if (i_clr_mask[2])              w_dr_d = '0;
            else if (i_load_code == CodeDr) w_dr_d = i_bus_data;
            else if (i_inc_mask[2])         w_dr_d = r_dr + DW'(1);

            if (i_clr_mask[3])              w_ac_d = '0;
            else if (i_load_code == CodeAc) w_ac_d = i_alu_data;
            else if (i_inc_mask[3])         w_ac_d = r_ac + DW'(1);

            if (i_load_code == CodeIr)      w_ir_d = i_bus_data;

            if (i_clr_mask[4])              w_tr_d = '0;
            else if (i_load_code == CodeTr) w_tr_d = i_bus_data;
            else if (i_inc_mask[4])         w_tr_d = r_tr + DW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Ack takes precedence over a timeout landing on the same edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_load_code == CodeMem) w_state_next = StWrite;
            StWrite: if (i_mem_wr_ack || (r_timer == TmoLast)) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy       = w_busy;
        o_mem_wr_req = w_busy;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ar        <= '0;
            r_pc        <= '0;
            r_dr        <= '0;
            r_ac        <= '0;
            r_ir        <= '0;
            r_tr        <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_timer     <= '0;
            r_wr_err    <= 1'b0;
        end else begin
            r_ar <= w_ar_d;
            r_pc <= w_pc_d;
            r_dr <= w_dr_d;
            r_ac <= w_ac_d;
            r_ir <= w_ir_d;
            r_tr <= w_tr_d;
            if (w_start) begin
                // Address is AR before any same-cycle increment.
                r_mem_addr  <= r_ar;
                r_mem_wdata <= i_bus_data;
                r_timer     <= '0;
            end else if (w_busy) begin
                r_timer <= r_timer + 8'd1;
                if (!i_mem_wr_ack && (r_timer == TmoLast)) r_wr_err <= 1'b1;
            end
        end
    end

    assign o_ar_outdata = r_ar;
    assign o_pc_outdata = r_pc;
    assign o_dr_outdata = r_dr;
    assign o_ac_outdata = r_ac;
    assign o_ir_outdata = r_ir;
    assign o_tr_outdata = r_tr;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_wr_err     = r_wr_err;

endmodule

// File: tb/tb_bus_loader.sv
// Bench for bus_loader: directed vector table, hand-written write/timeout/reset
// sequences, then randomized traffic against a cycle-level reference model.
module tb_bus_loader;

    localparam int unsigned Tmo = 4;

    localparam int S_AR = 0, S_PC = 1, S_DR = 2, S_AC = 3, S_IR = 4, S_TR = 5;
    localparam int S_REQ = 6, S_BUSY = 7, S_ERR = 8, S_ADDR = 9, S_WDATA = 10;

    logic        clk;
    logic        reset;
    logic [15:0] bus_data, alu_data;
    logic [2:0]  load_code;
    logic [4:0]  inc_mask, clr_mask;
    logic        mem_wr_ack;
    logic [11:0] ar, pc, mem_addr;
    logic [15:0] dr, ac, ir, tr, mem_wdata;
    logic        mem_wr_req, busy, wr_err;

    bus_loader #(.AW(12), .DW(16), .WR_TMO(Tmo)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_bus_data   (bus_data),
        .i_alu_data   (alu_data),
        .i_load_code  (load_code),
        .i_inc_mask   (inc_mask),
        .i_clr_mask   (clr_mask),
        .o_ar_outdata (ar),
        .o_pc_outdata (pc),
        .o_dr_outdata (dr),
        .o_ac_outdata (ac),
        .o_ir_outdata (ir),
        .o_tr_outdata (tr),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wr_req (mem_wr_req),
        .i_mem_wr_ack (mem_wr_ack),
        .o_busy       (busy),
        .o_wr_err     (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: registers indexed by their load code (1 AR .. 6 TR).
    logic [15:0] m_reg [7];
    logic        m_busy, m_err;
    int          m_cyc;
    logic [15:0] m_addr, m_wdata;

    function automatic logic [15:0] wmask(int r);
        return (r <= 2) ? 16'h0FFF : 16'hFFFF;
    endfunction

    task automatic model_step(input logic rst, input logic [2:0] code, input logic [4:0] inc,
                              input logic [4:0] clr, input logic [15:0] bus,
                              input logic [15:0] alu, input logic ack);
        logic [15:0] nv;
        int b;
        if (rst) begin
            for (int r = 0; r < 7; r++) m_reg[r] = 16'h0;
            m_busy = 0; m_err = 0; m_cyc = 0; m_addr = 0; m_wdata = 0;
            return;
        end
        if (m_busy) begin
            // m_cyc = number of cycles the request has been visible so far
            if (ack) m_busy = 0;
            else if (m_cyc == Tmo) begin m_busy = 0; m_err = 1; end
            else m_cyc++;
        end else begin
            if (code == 3'd7) begin
                m_busy = 1; m_cyc = 1; m_addr = m_reg[1]; m_wdata = bus;
            end
            for (int r = 1; r <= 6; r++) begin
                b  = (r == 6) ? 4 : r - 1;
                nv = m_reg[r];
                if (r != 5 && clr[b])          nv = 16'h0;
                else if (int'(code) == r)      nv = ((r == 4) ? alu : bus) & wmask(r);
                else if (r != 5 && inc[b])     nv = 16'((32'(m_reg[r]) + 1) & 32'(wmask(r)));
                m_reg[r] = nv;
            end
        end
    endtask

    function automatic logic [15:0] get_out(int sel);
        case (sel)
            S_AR:    return {4'h0, ar};
            S_PC:    return {4'h0, pc};
            S_DR:    return dr;
            S_AC:    return ac;
            S_IR:    return ir;
            S_TR:    return tr;
            S_REQ:   return {15'h0, mem_wr_req};
            S_BUSY:  return {15'h0, busy};
            S_ERR:   return {15'h0, wr_err};
            S_ADDR:  return {4'h0, mem_addr};
            default: return mem_wdata;
        endcase
    endfunction

    function automatic logic [15:0] model_out(int sel);
        case (sel)
            S_REQ, S_BUSY: return {15'h0, m_busy};
            S_ERR:         return {15'h0, m_err};
            S_ADDR:        return m_addr;
            S_WDATA:       return m_wdata;
            default:       return m_reg[sel + 1];
        endcase
    endfunction

    function automatic string out_name(int sel);
        string names [11] = '{"ar", "pc", "dr", "ac", "ir", "tr", "req", "busy", "err", "addr",
                              "wdata"};
        return names[sel];
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int s = 0; s <= S_WDATA; s++)
            check($sformatf("%s/%s", tag, out_name(s)), get_out(s), model_out(s));
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic apply(input string tag, input logic rst, input logic [2:0] code,
                         input logic [4:0] inc, input logic [4:0] clr, input logic [15:0] bus,
                         input logic [15:0] alu, input logic ack);
        reset = rst; load_code = code; inc_mask = inc; clr_mask = clr;
        bus_data = bus; alu_data = alu; mem_wr_ack = ack;
        model_step(rst, code, inc, clr, bus, alu, ack);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  code;
        logic [4:0]  inc;
        logic [4:0]  clr;
        logic [15:0] bus;
        logic [15:0] alu;
        int          sel;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 5'b00000, 5'b00000, 16'h0000, 16'h0000, S_AR, 16'h0000};
        vecs[1]  = '{1'b0, 3'd3, 5'b00000, 5'b00000, 16'hABCD, 16'h0000, S_DR, 16'hABCD};
        vecs[2]  = '{1'b0, 3'd1, 5'b00000, 5'b00000, 16'hABCD, 16'h0000, S_AR, 16'h0BCD};
        vecs[3]  = '{1'b0, 3'd2, 5'b00000, 5'b00000, 16'h0FFF, 16'h0000, S_PC, 16'h0FFF};
        vecs[4]  = '{1'b0, 3'd0, 5'b00010, 5'b00000, 16'h0000, 16'h0000, S_PC, 16'h0000};
        vecs[5]  = '{1'b0, 3'd6, 5'b00000, 5'b00000, 16'hFFFF, 16'h0000, S_TR, 16'hFFFF};
        vecs[6]  = '{1'b0, 3'd0, 5'b10000, 5'b00000, 16'h0000, 16'h0000, S_TR, 16'h0000};
        vecs[7]  = '{1'b0, 3'd4, 5'b00000, 5'b00000, 16'hFFFF, 16'h0005, S_AC, 16'h0005};
        vecs[8]  = '{1'b0, 3'd0, 5'b01000, 5'b01000, 16'h0000, 16'h0000, S_AC, 16'h0000};
        vecs[9]  = '{1'b0, 3'd4, 5'b00000, 5'b00000, 16'hFFFF, 16'h0F0F, S_AC, 16'h0F0F};
        vecs[10] = '{1'b0, 3'd5, 5'b11111, 5'b00000, 16'h1234, 16'h0000, S_IR, 16'h1234};
        vecs[11] = '{1'b0, 3'd0, 5'b00000, 5'b00000, 16'h0000, 16'h0000, S_AR, 16'h0BCE};
        vecs[12] = '{1'b0, 3'd0, 5'b00000, 5'b00000, 16'h0000, 16'h0000, S_AC, 16'h0F10};
        vecs[13] = '{1'b0, 3'd3, 5'b00000, 5'b11111, 16'h7777, 16'h0000, S_DR, 16'h0000};
        vecs[14] = '{1'b0, 3'd0, 5'b00000, 5'b11111, 16'h0000, 16'h0000, S_IR, 16'h1234};
        vecs[15] = '{1'b0, 3'd1, 5'b00001, 5'b00000, 16'h0123, 16'h0000, S_AR, 16'h0123};

        for (int i = 0; i < 16; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].code, vecs[i].inc,
                  vecs[i].clr, vecs[i].bus, vecs[i].alu, 1'b0);
            check($sformatf("vec%0d_%s", i, out_name(vecs[i].sel)),
                  get_out(vecs[i].sel), vecs[i].exp);
        end

        // Write with AR increment in the request cycle; ack arrives on the third cycle.
        apply("wr0", 1'b0, 3'd7, 5'b00001, 5'b00000, 16'h5A5A, 16'h0, 1'b0);
        check("wr_req", {15'h0, mem_wr_req}, 16'h1);
        check("wr_addr", {4'h0, mem_addr}, 16'h0123);
        check("wr_data", mem_wdata, 16'h5A5A);
        check("wr_ar_inc", {4'h0, ar}, 16'h0124);
        apply("wr1", 1'b0, 3'd3, 5'b11111, 5'b00000, 16'h1111, 16'h0, 1'b0);
        check("wr_dr_frozen", dr, 16'h0000);
        check("wr_ar_frozen", {4'h0, ar}, 16'h0124);
        apply("wr2", 1'b0, 3'd0, 5'b00000, 5'b00000, 16'h2222, 16'h0, 1'b0);
        check("wr_busy_c2", {15'h0, busy}, 16'h1);
        check("wr_addr_hold", {4'h0, mem_addr}, 16'h0123);
        apply("wr3", 1'b0, 3'd0, 5'b00000, 5'b00000, 16'h0000, 16'h0, 1'b1);
        check("wr_busy_done", {15'h0, busy}, 16'h0);
        check("wr_err_clean", {15'h0, wr_err}, 16'h0);

        // Ack while idle must do nothing.
        apply("idle_ack", 1'b0, 3'd0, 5'b00000, 5'b00000, 16'h0000, 16'h0, 1'b1);
        check("idle_ack_busy", {15'h0, busy}, 16'h0);

        // Timeout: request stays up for Tmo cycles then drops with a sticky error.
        apply("to0", 1'b0, 3'd7, 5'b00000, 5'b00000, 16'hBEEF, 16'h0, 1'b0);
        for (int k = 1; k < int'(Tmo); k++) begin
            apply($sformatf("to%0d", k), 1'b0, 3'd0, 5'b00000, 5'b00000, 16'h0, 16'h0, 1'b0);
            check($sformatf("to_req_c%0d", k), {15'h0, mem_wr_req}, 16'h1);
        end
        apply("to_end", 1'b0, 3'd0, 5'b00000, 5'b00000, 16'h0, 16'h0, 1'b0);
        check("to_req_drop", {15'h0, mem_wr_req}, 16'h0);
        check("to_err", {15'h0, wr_err}, 16'h1);
        apply("to_next0", 1'b0, 3'd7, 5'b00000, 5'b00000, 16'h1357, 16'h0, 1'b0);
        check("to_next_addr", {4'h0, mem_addr}, 16'h0124);
        check("to_next_data", mem_wdata, 16'h1357);
        apply("to_next1", 1'b0, 3'd0, 5'b00000, 5'b00000, 16'h0, 16'h0, 1'b1);
        check("to_next_done", {15'h0, busy}, 16'h0);
        check("to_err_sticky", {15'h0, wr_err}, 16'h1);

        // Reset in the middle of a write.
        apply("rw0", 1'b0, 3'd7, 5'b00000, 5'b00000, 16'h4444, 16'h0, 1'b0);
        apply("rw1", 1'b1, 3'd0, 5'b00000, 5'b00000, 16'h0, 16'h0, 1'b0);
        check("rst_req", {15'h0, mem_wr_req}, 16'h0);
        check("rst_busy", {15'h0, busy}, 16'h0);
        check("rst_err", {15'h0, wr_err}, 16'h0);
        check("rst_ar", {4'h0, ar}, 16'h0000);
        check("rst_ir", ir, 16'h0000);

        // Randomized traffic, compared against the model every cycle.
        for (int c = 0; c < 400; c++) begin
            logic        r_rst, r_ack;
            logic [2:0]  r_code;
            logic [4:0]  r_inc, r_clr;
            r_rst  = ($urandom_range(0, 99) == 0);
            r_ack  = ($urandom_range(0, 3) == 0);
            r_code = 3'($urandom_range(0, 7));
            r_inc  = 5'($urandom & $urandom);
            r_clr  = ($urandom_range(0, 3) == 0) ? 5'($urandom & $urandom) : 5'b00000;
            apply($sformatf("rnd%0d", c), r_rst, r_code, r_inc, r_clr, 16'($urandom),
                  16'($urandom), r_ack);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
